// File: rtl/f8_divider.sv
// f8_divider: 16-bit sequential restoring divider for the f8 core.
// Signed/unsigned, one quotient bit per cycle, ALU-style z/n/c flags.
module f8_divider (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        signed_in,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        z_out,
    output logic        n_out,
    output logic        c_out
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [15:0] work;
    logic [15:0] prem;
    logic [15:0] dsr_mag;
    logic [3:0]  count;
    logic        q_sign;
    logic        r_sign;
    logic        ovf;

    logic        accept;
    logic        div_zero;
    logic [16:0] shifted;
    logic        fits;
    logic [15:0] trial;
    logic [15:0] q_fix;
    logic [15:0] r_fix;

    assign accept   = start && (state == IDLE || state == DONE);
    assign div_zero = (divisor == 16'd0);
    assign busy     = (state == CALC) || (state == FIX);
    assign done     = (state == DONE);

    // Restoring step and sign fix-up; a kept difference is always below the
    // divisor, so the low 16 bits of the subtraction are exact.
    always_comb begin
        shifted = {prem, work[15]};
        fits    = (shifted >= {1'b0, dsr_mag});
        trial   = shifted[15:0] - dsr_mag;
        q_fix   = q_sign ? (16'd0 - work) : work;
        r_fix   = r_sign ? (16'd0 - prem) : prem;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start is only honoured in IDLE or DONE.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = div_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (count == 4'd0) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = DONE;
            end
            DONE: begin
                if (start) begin
                    state_next = div_zero ? DONE : CALC;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, iteration, and result/flag update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work      <= 16'd0;
            prem      <= 16'd0;
            dsr_mag   <= 16'd0;
            count     <= 4'd0;
            q_sign    <= 1'b0;
            r_sign    <= 1'b0;
            ovf       <= 1'b0;
            quotient  <= 16'd0;
            remainder <= 16'd0;
            z_out     <= 1'b1;
            n_out     <= 1'b0;
            c_out     <= 1'b0;
        end else if (accept) begin
            q_sign  <= signed_in & (dividend[15] ^ divisor[15]);
            r_sign  <= signed_in & dividend[15];
            work    <= (signed_in & dividend[15]) ? (16'd0 - dividend) : dividend;
            dsr_mag <= (signed_in & divisor[15]) ? (16'd0 - divisor) : divisor;
            prem    <= 16'd0;
            count   <= 4'd15;
            ovf     <= signed_in && (dividend == 16'h8000) && (divisor == 16'hFFFF);
            if (div_zero) begin
                quotient  <= 16'hFFFF;
                remainder <= dividend;
                z_out     <= 1'b0;
                n_out     <= 1'b1;
                c_out     <= 1'b1;
            end
        end else if (state == CALC) begin
            work  <= {work[14:0], fits};
            prem  <= fits ? trial : shifted[15:0];
            count <= count - 4'd1;
        end else if (state == FIX) begin
            quotient  <= q_fix;
            remainder <= r_fix;
            z_out     <= (q_fix == 16'd0);
            n_out     <= q_fix[15];
            c_out     <= ovf;
        end
    end

endmodule

// File: tb/tb_f8_divider.sv
// tb_f8_divider: directed scoreboard bench for f8_divider.
// Expected results come from a behavioural division model.
module tb_f8_divider;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        z;
        logic        n;
        logic        c;
    } res_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic        signed_in;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        z_out;
    logic        n_out;
    logic        c_out;

    res_t sb[$];
    res_t last;
    int   n_checks;
    int   n_fail;

    f8_divider dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .signed_in (signed_in),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .z_out     (z_out),
        .n_out     (n_out),
        .c_out     (c_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic s);
        res_t res;
        int   sa;
        int   sb_;
        res.c = 1'b0;
        if (b == 16'd0) begin
            res.q = 16'hFFFF;
            res.r = a;
            res.c = 1'b1;
        end else if (!s) begin
            res.q = a / b;
            res.r = a % b;
        end else if (a == 16'h8000 && b == 16'hFFFF) begin
            res.q = 16'h8000;
            res.r = 16'h0000;
            res.c = 1'b1;
        end else begin
            sa    = $signed(a);
            sb_   = $signed(b);
            res.q = 16'(sa / sb_);
            res.r = 16'(sa % sb_);
        end
        res.z = (res.q == 16'd0);
        res.n = res.q[15];
        return res;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_q"}, 32'(quotient), 32'd0);
        chk({tag, "_r"}, 32'(remainder), 32'd0);
        chk({tag, "_z"}, 32'(z_out), 32'd1);
        chk({tag, "_n"}, 32'(n_out), 32'd0);
        chk({tag, "_c"}, 32'(c_out), 32'd0);
    endtask

    // Drive a request at the current negedge; optionally record expectation.
    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input logic s, input bit push);
        dividend  = a;
        divisor   = b;
        signed_in = s;
        start     = 1'b1;
        if (push) sb.push_back(model(a, b, s));
    endtask

    // Wait for done, checking latency, busy length, output hold, results.
    task automatic wait_done(input int exp_lat, input int exp_busy,
                             input int pulse_at, input bit hold);
        int   lat;
        int   bc;
        res_t e;
        lat = 0;
        bc  = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1 && !hold) start = 1'b0;
            if (lat == pulse_at) begin
                start    = 1'b1;
                dividend = 16'hDEAD;
                divisor  = 16'h0001;
            end
            if (lat == pulse_at + 1) start = 1'b0;
            if (busy) bc++;
            if (lat == 1 && !done) begin
                chk("hold_q", 32'(quotient), 32'(last.q));
                chk("hold_r", 32'(remainder), 32'(last.r));
            end
        end while (!done && lat < 60);
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("busy_cycles", 32'(bc), 32'(exp_busy));
        if (sb.size() == 0) begin
            chk("sb_nonempty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("quotient", 32'(quotient), 32'(e.q));
            chk("remainder", 32'(remainder), 32'(e.r));
            chk("z_out", 32'(z_out), 32'(e.z));
            chk("n_out", 32'(n_out), 32'(e.n));
            chk("c_out", 32'(c_out), 32'(e.c));
            last = e;
        end
        if (!hold) begin
            @(negedge clk);
            chk("done_pulse", 32'(done), 32'd0);
        end
    endtask

    initial begin
        int dcnt;
        n_checks  = 0;
        n_fail    = 0;
        last.q    = 16'd0;
        last.r    = 16'd0;
        last.z    = 1'b1;
        last.n    = 1'b0;
        last.c    = 1'b0;
        reset     = 1'b1;
        start     = 1'b0;
        signed_in = 1'b0;
        dividend  = 16'd0;
        divisor   = 16'd0;
        repeat (2) @(negedge clk);
        chk_reset_vals("rst");
        reset = 1'b0;
        @(negedge clk);

        issue(16'h03E8, 16'h0007, 1'b0, 1'b1);
        wait_done(18, 17, -1, 1'b0);
        issue(16'hFFF9, 16'h0002, 1'b1, 1'b1);
        wait_done(18, 17, -1, 1'b0);
        issue(16'h0007, 16'hFFFE, 1'b1, 1'b1);
        wait_done(18, 17, -1, 1'b0);
        issue(16'h1234, 16'h0000, 1'b0, 1'b1);
        wait_done(1, 0, -1, 1'b0);
        issue(16'h8000, 16'hFFFF, 1'b1, 1'b1);
        wait_done(18, 17, -1, 1'b0);
        issue(16'h8000, 16'hFFFF, 1'b0, 1'b1);
        wait_done(18, 17, -1, 1'b0);

        for (int i = 0; i < 6; i++) begin
            issue(16'($urandom), 16'($urandom_range(1, 65535)), i[0], 1'b1);
            wait_done(18, 17, -1, 1'b0);
        end

        // start pulsed during CALC cycle 5 must be ignored
        issue(16'h7531, 16'h0123, 1'b0, 1'b1);
        wait_done(18, 17, 5, 1'b0);

        // back-to-back: start held through DONE with 100 / 10
        issue(16'hC000, 16'h0003, 1'b1, 1'b1);
        wait_done(18, 17, -1, 1'b1);
        issue(16'd100, 16'd10, 1'b0, 1'b1);
        wait_done(18, 17, -1, 1'b0);

        // divide-by-zero back-to-back with a normal op
        issue(16'h8001, 16'h0000, 1'b1, 1'b1);
        wait_done(1, 0, -1, 1'b1);
        issue(16'hFF00, 16'h0010, 1'b1, 1'b1);
        wait_done(18, 17, -1, 1'b0);

        // reset in CALC cycle 8: immediate reset values, no done
        issue(16'h4321, 16'h0005, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        reset = 1'b0;
        dcnt  = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("no_done_after_reset", 32'(dcnt), 32'd0);
        last.q = 16'd0;
        last.r = 16'd0;
        issue(16'd100, 16'd10, 1'b0, 1'b1);
        wait_done(18, 17, -1, 1'b0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
